ldl_rr_dispatch: RTL and testbench
==================================

// Module: ldl_rr_dispatch
// PURPOSE
// Round-robin dispatcher; the distribution side of the rr arbiters. Accepts one
// upstream valid/ready stream and hands each item to one of REQ_WIDTH downstream
// channels in round-robin order. Per-channel credit counters gate the choice;
// the consumer returns credits. Used where work fans out to parallel engines.
// PARAMETERS
// BIN_WIDTH    3  channel index width; REQ_WIDTH = 1 << BIN_WIDTH channels
// DATA_WIDTH   8  payload width
// CREDIT_WIDTH 2  per-channel credit counter width; max = 2**CREDIT_WIDTH-1
// CREDIT_INIT  2  credits loaded per channel at reset (1..max)
// PORTS
// clk        in   1           clock
// rst        in   1           asynchronous reset, active-high
// in_valid   in   1           upstream item present
// in_data    in   DATA_WIDTH  upstream payload
// in_ready   out  1           dispatcher can accept this cycle
// dst_en     in   REQ_WIDTH   per-channel enable mask; 0 = never selected
// credit_ret in   REQ_WIDTH   1-cycle pulse per bit: return one credit to channel
// out_valid  out  1           1-cycle pulse: item dispatched
// out_bin    out  BIN_WIDTH   destination channel index
// out_sel    out  REQ_WIDTH   one-hot of out_bin, all-zero when out_valid=0
// out_data   out  DATA_WIDTH  dispatched payload
// ovf_err    out  1           sticky: credit returned to a full counter
// BEHAVIOUR
// - Reset (async, any time incl. mid-transfer): out_valid=0, out_sel=0,
//   out_bin=0, out_data=0, ovf_err=0, ptr=0, every credit=CREDIT_INIT.
//   An item presented during reset is not accepted and not dispatched.
// - eligible[i] = dst_en[i] & (credit[i] != 0), from registered credit only;
//   same-cycle credit_ret does not make a channel eligible until next cycle.
// - in_ready = |eligible (combinational; no dependence on in_valid).
// - Selection: first eligible index scanning ptr, ptr+1, ..., wrapping
//   REQ_WIDTH-1 -> 0. Combinational from registered ptr/credit/dst_en.
// - Accept = in_valid & in_ready. On accept at edge N:
//   out_valid=1, out_bin=sel, out_sel=1<<sel, out_data=in_data, visible
//   after edge N (latency 1); credit[sel] -= 1; ptr <= sel+1 mod REQ_WIDTH.
// - No accept: out_valid=0, out_sel=0, out_bin/out_data hold; ptr holds.
// - Back-to-back accepts every cycle allowed; out_valid stays high.
// - Credit update per channel: next = credit - dec + ret (dec = accepted to i,
//   ret = credit_ret[i]). dec & ret same cycle -> unchanged.
// - ret with credit==max and no dec: credit holds at max, ovf_err <= 1
//   (cleared only by reset). Decrement never underflows (eligibility rule).
// - dst_en change takes effect same cycle; disabled channel keeps its credits
//   and still accepts returns.
// - All channels ineligible: in_ready=0, upstream stalls, ptr holds.
// TESTING
// 1 Reset: BIN_WIDTH=3, CREDIT_INIT=2, dst_en=ff, in_valid=1 continuous, no
//   returns -> out_bin 0,1,..,7,0,1,..,7 (16 pulses), then in_ready=0.
// 2 dst_en=a5, continuous in_valid, credit_ret=out_sel each cycle -> out_bin
//   sequence 0,2,5,7,0,2,... forever, in_ready never drops.
// 3 Credit exhaust/return: dst_en=01, CREDIT_INIT=2 -> 2 dispatches to 0,
//   in_ready=0; pulse credit_ret=01 -> in_ready=1 next cycle, 1 more dispatch.
// 4 Simultaneous: channel 0 at credit 1, accept to 0 with credit_ret[0]=1
//   same cycle -> credit stays 1, channel 0 eligible again next cycle.
// 5 Overflow: at reset credits=2, pulse credit_ret=08 twice (max 3) ->
//   ovf_err=0 after first, 1 after second, stays 1 until rst.
// 6 Async rst asserted mid-burst between edges -> out_valid=0 immediately,
//   after release first dispatch goes to channel 0 with in_data=55 -> out_data=55.

Source files
------------

// File: rtl/ldl_rr_dispatch.sv
// Round-robin dispatcher: fans one valid/ready stream out to REQ_WIDTH channels,
// choosing the next enabled channel with credit after the last one served.
module ldl_rr_dispatch #(
  parameter int BIN_WIDTH    = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int CREDIT_WIDTH = 2,
  parameter int CREDIT_INIT  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  input  logic [(1<<BIN_WIDTH)-1:0]  dst_en,
  input  logic [(1<<BIN_WIDTH)-1:0]  credit_ret,
  output logic                       out_valid,
  output logic [BIN_WIDTH-1:0]       out_bin,
  output logic [(1<<BIN_WIDTH)-1:0]  out_sel,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       ovf_err
);

  localparam int REQ_WIDTH = 1 << BIN_WIDTH;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = '1;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_RST = CREDIT_WIDTH'(CREDIT_INIT);

  logic [CREDIT_WIDTH-1:0] credit     [REQ_WIDTH];
  logic [CREDIT_WIDTH-1:0] credit_nxt [REQ_WIDTH];
  logic [BIN_WIDTH-1:0]    ptr;
  logic [REQ_WIDTH-1:0]    eligible;
  logic [REQ_WIDTH-1:0]    dec;
  logic [BIN_WIDTH-1:0]    sel;
  logic                    accept;
  logic                    ovf_hit;

  // Eligibility looks only at registered credit, so a return this cycle
  // cannot enable a channel until the next one.
  always_comb begin
    for (int i = 0; i < REQ_WIDTH; i++) begin
      eligible[i] = dst_en[i] & (credit[i] != '0);
    end
  end

  assign in_ready = |eligible;
  assign accept   = in_valid & in_ready;

  // Scan from the far end back towards ptr so the nearest eligible index,
  // counting forward from ptr with wrap, is the one left in sel.
  always_comb begin
    logic [BIN_WIDTH-1:0] idx;
    // NOTE: every combinational output gets a default before any conditional
    // assignment; otherwise a path that skips it infers a latch.
    sel = ptr;
    idx = '0;
    for (int k = REQ_WIDTH - 1; k >= 0; k--) begin
      idx = ptr + BIN_WIDTH'(k);
      if (eligible[idx]) sel = idx;
    end
  end

  assign dec = accept ? (REQ_WIDTH'(1) << sel) : '0;

  always_comb begin
    ovf_hit = 1'b0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      credit_nxt[i] = credit[i];
      unique case ({dec[i], credit_ret[i]})
        2'b10: credit_nxt[i] = credit[i] - 1'b1;
        2'b01: begin
          if (credit[i] == CREDIT_MAX) ovf_hit = 1'b1;
          else                         credit_nxt[i] = credit[i] + 1'b1;
        end
        default: credit_nxt[i] = credit[i];
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the credit array is a set of live counters, not storage, so it
      // must be loaded on reset like any other state register.
      for (int i = 0; i < REQ_WIDTH; i++) credit[i] <= CREDIT_RST;
      ptr     <= '0;
      ovf_err <= 1'b0;
    end else begin
      for (int i = 0; i < REQ_WIDTH; i++) credit[i] <= credit_nxt[i];
      if (accept)  ptr     <= sel + 1'b1;
      if (ovf_hit) ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_sel   <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= accept;
      out_sel   <= dec;
      if (accept) begin
        out_bin  <= sel;
        out_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_ldl_rr_dispatch.sv
// Scoreboard bench for ldl_rr_dispatch: directed stimulus queues expected
// dispatches, a negedge monitor pops and compares each output pulse.
module tb_ldl_rr_dispatch;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] dst_en;
  logic [7:0] credit_ret;
  logic       out_valid;
  logic [2:0] out_bin;
  logic [7:0] out_sel;
  logic [7:0] out_data;
  logic       ovf_err;

  typedef struct {
    logic [2:0] bin;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ldl_rr_dispatch #(
    .BIN_WIDTH(3), .DATA_WIDTH(8), .CREDIT_WIDTH(2), .CREDIT_INIT(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .dst_en(dst_en), .credit_ret(credit_ret),
    .out_valid(out_valid), .out_bin(out_bin), .out_sel(out_sel),
    .out_data(out_data), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] bin, input logic [7:0] data);
    exp_t e;
    e.bin  = bin;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    credit_ret = '0;
    step();
    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dispatch_bin", 32'(out_bin), 32'hffff_ffff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_bin",  32'(out_bin),  32'(e.bin));
          check("out_sel",  32'(out_sel),  32'(8'd1 << e.bin));
          check("out_data", 32'(out_data), 32'(e.data));
        end
      end else begin
        check("out_sel_idle", 32'(out_sel), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    dst_en     = 8'hff;
    credit_ret = '0;

    // Test 1: reset state, then 16 dispatches 0..7,0..7, then stall.
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bin",   32'(out_bin),   32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_ovf_err",   32'(ovf_err),   32'd0);
    for (int i = 0; i < 16; i++) push(3'(i % 8), 8'h10 + 8'(i));
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'h10 + 8'(i);
      check("t1_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    check("t1_exhausted", 32'(in_ready), 32'd0);
    step();
    step();
    check("t1_still_stalled", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Test 2: mask a5 with immediate credit return -> 0,2,5,7 repeating.
    do_reset();
    dst_en   = 8'ha5;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      case (i % 4)
        0: push(3'd0, 8'h20 + 8'(i));
        1: push(3'd2, 8'h20 + 8'(i));
        2: push(3'd5, 8'h20 + 8'(i));
        default: push(3'd7, 8'h20 + 8'(i));
      endcase
    end
    for (int i = 0; i < 12; i++) begin
      in_data    = 8'h20 + 8'(i);
      credit_ret = out_sel;
      check("t2_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_valid   = 1'b0;
    credit_ret = out_sel;
    step();
    credit_ret = '0;

    // Test 3: single channel exhausts two credits, one return allows one more.
    do_reset();
    dst_en   = 8'h01;
    in_valid = 1'b1;
    push(3'd0, 8'h30);
    push(3'd0, 8'h31);
    in_data = 8'h30;
    step();
    in_data = 8'h31;
    step();
    check("t3_exhausted", 32'(in_ready), 32'd0);
    step();
    credit_ret = 8'h01;
    check("t3_ret_same_cycle", 32'(in_ready), 32'd0);
    step();
    credit_ret = '0;
    check("t3_ret_next_cycle", 32'(in_ready), 32'd1);
    push(3'd0, 8'h32);
    in_data = 8'h32;
    step();
    check("t3_exhausted_again", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Test 4: accept and return on the same channel in the same cycle.
    do_reset();
    dst_en   = 8'h01;
    in_valid = 1'b1;
    push(3'd0, 8'h40);
    push(3'd0, 8'h41);
    push(3'd0, 8'h42);
    in_data = 8'h40;
    step();
    in_data    = 8'h41;
    credit_ret = 8'h01;
    step();
    credit_ret = '0;
    check("t4_still_eligible", 32'(in_ready), 32'd1);
    in_data = 8'h42;
    step();
    check("t4_now_empty", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Test 5: return into a full counter sets the sticky overflow flag.
    do_reset();
    dst_en     = 8'hff;
    credit_ret = 8'h08;
    step();
    credit_ret = '0;
    check("t5_ovf_after_first", 32'(ovf_err), 32'd0);
    credit_ret = 8'h08;
    step();
    credit_ret = '0;
    check("t5_ovf_after_second", 32'(ovf_err), 32'd1);
    step();
    step();
    check("t5_ovf_sticky", 32'(ovf_err), 32'd1);
    do_reset();
    check("t5_ovf_cleared", 32'(ovf_err), 32'd0);

    // Test 6: async reset between edges mid-burst.
    dst_en   = 8'hff;
    in_valid = 1'b1;
    push(3'd0, 8'h60);
    push(3'd1, 8'h61);
    push(3'd2, 8'h62);
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h60 + 8'(i);
      step();
    end
    @(negedge clk);
    #1;
    check("t6_pre_rst_valid", 32'(out_valid), 32'd1);
    rst     = 1'b1;
    in_data = 8'h55;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_out_sel",   32'(out_sel),   32'd0);
    check("t6_rst_out_data",  32'(out_data),  32'd0);
    step();
    step();
    check("t6_no_dispatch_in_rst", 32'(out_valid), 32'd0);
    push(3'd0, 8'h55);
    rst = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
